io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Two-master arbiter and access sequencer for the I/O peripheral bus; sits between the CPU data port (master 0) and a DMA/debug port (master 1) upstream, and the I/O controller slave port downstream. Grants one request at a time, holds address/byte-enables/write data stable for a programmable access window, issues a single-cycle read or write strobe, captures read data and returns a one-cycle acknowledge to the granted master.

## Interface
- ACCESS_CYCLES, 2, cycles the slave address is held per transaction (legal 1..15); read data is captured in the last one
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- m_req  in  2  per-master request, held high until its ack
- m_we  in  2  per-master write enable (1 = write, 0 = read)
- m0_addr, m1_addr  in  11  per-master byte address
- m0_wdata, m1_wdata  in  32  per-master write data
- m0_be, m1_be  in  4  per-master byte enables
- m_ack  out  2  per-master one-cycle acknowledge, registered
- m_rdata  out  32  shared read data, valid while the corresponding m_ack bit is high
- s_read  out  1  slave read strobe
- s_write  out  1  slave write strobe
- s_address  out  11  slave address
- s_data_in  out  32  slave write data
- s_be  out  4  slave byte enables
- s_data_out  in  32  slave read data (combinational from slave)

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: if any m_req bit high, pick grant g, register g's addr/wdata/be/we into the slave-side registers, load counter = ACCESS_CYCLES-1, go ACCESS. Otherwise stay.
- ACCESS: s_address/s_data_in/s_be driven from registers for all ACCESS cycles. s_write (we=1) or s_read (we=0) high in the first ACCESS cycle only, never both. Counter decrements each cycle; at counter==0, if read, capture s_data_out into m_rdata; go ACK.
- ACK: m_ack[g] high for exactly this cycle; strobes low; go IDLE. m_rdata holds value until the next read capture; writes never modify m_rdata.
- Master rule: req must drop in the cycle after ack is seen; a req still high in the following IDLE cycle is a new transaction.
- Request inputs are sampled only in IDLE; changes during ACCESS/ACK are ignored. Deasserting req mid-transaction does not abort it; ack is still issued.
- Selection: only one requester -> it wins. Both -> per Configuration.
- last_grant register updated on every grant.

## Timing
- Reset values: m_ack=2'b00, m_rdata=0, s_read=0, s_write=0, s_address=0, s_data_in=0, s_be=0, state=IDLE, last_grant=1.
- Latency: req sampled high at edge E -> strobe high in cycle after E -> m_ack high ACCESS_CYCLES+1 cycles after E. Default: req asserted cycle 0, strobe cycle 1, capture end of cycle 2, ack cycle 3.
- Throughput: one dead IDLE cycle between transactions; back-to-back from one master costs ACCESS_CYCLES+2 cycles each.
- All outputs registered; no combinational path from m_* inputs to s_* outputs or m_ack.
- rst during ACCESS or ACK: next cycle is IDLE with all outputs at reset values; no ack issued for the interrupted transaction; any side effect already strobed is not undone.
- ACCESS_CYCLES=1: strobe and capture in the same cycle.

## Configuration
- IO_ARB_RR_EN defined: round-robin; on simultaneous requests grant the master that is not last_grant (after reset master 0 wins first).
- IO_ARB_RR_EN undefined: fixed priority, master 0 always wins on simultaneous requests; last_grant still maintained but unused.

## Test plan
- Single read, master 0, addr 0x010, s_data_out=0x0000A5A5 -> s_read high exactly cycle 1 with s_address=0x010, m_ack=2'b01 in cycle 3, m_rdata=0x0000A5A5.
- Single write, master 1, addr 0x020, wdata 0xDEADBEEF, be 4'b0001 -> s_write one cycle, s_data_in=0xDEADBEEF, s_be=0001, m_ack=2'b10 in cycle 3, m_rdata unchanged.
- Both request continuously, RR build -> grants alternate 0,1,0,1; fixed build -> master 0 always granted while it requests, master 1 granted only after m_req[0] drops.
- ACCESS_CYCLES=4, read where s_data_out changes 0x1->0x2 in last access cycle -> captured 0x2; ack 5 cycles after sampling edge; strobe only one cycle.
- rst pulsed in the second ACCESS cycle -> no m_ack, all outputs reset next cycle; fresh request afterwards completes normally and master 0 wins a tie.
- Master drops req mid-ACCESS -> ack still issued; req held high after ack -> second transaction begins after one IDLE cycle.

Source files
------------

// File: rtl/io_bus_arbiter_if.sv
// Signal bundle shared by the two requesting masters, the I/O bus arbiter and the I/O slave port.
// The arbiter connects through the slave modport; requesters and slave device use the master modport.
interface io_bus_arbiter_if;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [10:0] m0_addr;
    logic [10:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic [3:0]  m0_be;
    logic [3:0]  m1_be;
    logic [1:0]  m_ack;
    logic [31:0] m_rdata;
    logic        s_read;
    logic        s_write;
    logic [10:0] s_address;
    logic [31:0] s_data_in;
    logic [3:0]  s_be;
    logic [31:0] s_data_out;

    modport slave (
        input  m_req, m_we, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_be, m1_be, s_data_out,
        output m_ack, m_rdata, s_read, s_write, s_address, s_data_in, s_be
    );

    modport master (
        output m_req, m_we, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_be, m1_be, s_data_out,
        input  m_ack, m_rdata, s_read, s_write, s_address, s_data_in, s_be
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-master I/O bus arbiter: grants one request, holds the slave access for ACCESS_CYCLES, acks.
// Define IO_ARB_RR_EN for round-robin tie breaking; otherwise master 0 has fixed priority.
module io_bus_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    io_bus_arbiter_if.slave bus
);

`ifdef IO_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    typedef struct packed {
        logic        we;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       gnt, gnt_sel, last_grant, we_q;
    req_t       sel_req;

    // Ties go to the master that was not granted last when round-robin is built in.
    always_comb begin
        gnt_sel = 1'b0;
        if (bus.m_req == 2'b10)
            gnt_sel = 1'b1;
        else if (bus.m_req == 2'b11)
            gnt_sel = RR_EN & ~last_grant;
    end

    always_comb begin
        if (gnt_sel) begin
            sel_req.we    = bus.m_we[1];
            sel_req.addr  = bus.m1_addr;
            sel_req.wdata = bus.m1_wdata;
            sel_req.be    = bus.m1_be;
        end else begin
            sel_req.we    = bus.m_we[0];
            sel_req.addr  = bus.m0_addr;
            sel_req.wdata = bus.m0_wdata;
            sel_req.be    = bus.m0_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|bus.m_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and ack are set on the transition into the cycle they belong to, so all are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 4'd0;
            gnt           <= 1'b0;
            last_grant    <= 1'b1;
            we_q          <= 1'b0;
            bus.m_ack     <= 2'b00;
            bus.m_rdata   <= 32'd0;
            bus.s_read    <= 1'b0;
            bus.s_write   <= 1'b0;
            bus.s_address <= 11'd0;
            bus.s_data_in <= 32'd0;
            bus.s_be      <= 4'd0;
        end else begin
            bus.m_ack   <= 2'b00;
            bus.s_read  <= 1'b0;
            bus.s_write <= 1'b0;
            case (state)
                IDLE: if (|bus.m_req) begin
                    gnt           <= gnt_sel;
                    last_grant    <= gnt_sel;
                    we_q          <= sel_req.we;
                    bus.s_address <= sel_req.addr;
                    bus.s_data_in <= sel_req.wdata;
                    bus.s_be      <= sel_req.be;
                    bus.s_write   <= sel_req.we;
                    bus.s_read    <= ~sel_req.we;
                    cnt           <= CNT_LOAD;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_q) bus.m_rdata <= bus.s_data_out;
                        bus.m_ack <= gnt ? 2'b10 : 2'b01;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant time, strobe/capture/ack cycles derived from the access window).
module tb_io_bus_arbiter;
    localparam int AC = 2;
`ifdef IO_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        slv_fixed_en;
    logic [31:0] slv_fixed;
    logic [31:0] s4_data;

    io_bus_arbiter_if bus ();
    io_bus_arbiter_if bus4 ();

    io_bus_arbiter #(.ACCESS_CYCLES(AC)) dut  (.clk(clk), .rst(rst), .bus(bus));
    io_bus_arbiter #(.ACCESS_CYCLES(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave read data varies with address and cycle so a capture in the wrong cycle is visible.
    function automatic logic [31:0] rd_fn(logic [10:0] a, int c);
        return (32'(c) * 32'h9E3779B1) ^ {21'd0, a};
    endfunction

    function automatic logic pick(logic [1:0] req, logic last);
        if (req == 2'b01) return 1'b0;
        if (req == 2'b10) return 1'b1;
        return RR ? ~last : 1'b0;
    endfunction

    assign bus.s_data_out  = slv_fixed_en ? slv_fixed : rd_fn(bus.s_address, cyc);
    assign bus4.s_data_out = s4_data;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.m_req = 2'b00;  bus.m_we = 2'b00;
        bus.m0_addr = '0;   bus.m1_addr = '0;  bus.m0_wdata = '0; bus.m1_wdata = '0;
        bus.m0_be = '0;     bus.m1_be = '0;
        bus4.m_req = 2'b00; bus4.m_we = 2'b00;
        bus4.m0_addr = '0;  bus4.m1_addr = '0; bus4.m0_wdata = '0; bus4.m1_wdata = '0;
        bus4.m0_be = '0;    bus4.m1_be = '0;
        slv_fixed_en = 1'b1; slv_fixed = '0; s4_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        checks++;
        if (bus.m_ack !== 2'b00 || bus.s_read !== 1'b0 || bus.s_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: ack=%b rd=%b wr=%b want 00/0/0", bus.m_ack, bus.s_read, bus.s_write);
        end
        checks++;
        if (bus.m_rdata !== 32'd0 || bus.s_address !== 11'd0 || bus.s_data_in !== 32'd0 || bus.s_be !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%h want all 0",
                     bus.m_rdata, bus.s_address, bus.s_data_in, bus.s_be);
        end
        checks++;
        if (bus4.m_ack !== 2'b00 || bus4.m_rdata !== 32'd0 || bus4.s_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut4: ack=%b rdata=%h rd=%b want 0", bus4.m_ack, bus4.m_rdata, bus4.s_read);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        slv_fixed_en = 1'b1; slv_fixed = 32'h0000A5A5;
        bus.m0_addr = 11'h010; bus.m_we = 2'b00; bus.m_req = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (bus.s_read !== (c == 1) || bus.s_write !== 1'b0) begin
                errors++;
                $display("FAIL rd_strobe c%0d: rd=%b wr=%b want %b/0", c, bus.s_read, bus.s_write, c == 1);
            end
            checks++;
            if (bus.m_ack !== ((c == 3) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL rd_ack c%0d: got %b", c, bus.m_ack);
            end
            if (c == 1) begin
                checks++;
                if (bus.s_address !== 11'h010) begin
                    errors++; $display("FAIL rd_addr: got %h want 010", bus.s_address);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.m_rdata !== 32'h0000A5A5) begin
                    errors++; $display("FAIL rd_data: got %h want 0000a5a5", bus.m_rdata);
                end
                bus.m_req = 2'b00;
            end
        end
    endtask

    task automatic test_single_write();
        bus.m1_addr = 11'h020; bus.m1_wdata = 32'hDEADBEEF; bus.m1_be = 4'b0001;
        bus.m_we = 2'b10; bus.m_req = 2'b10;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (bus.s_write !== (c == 1) || bus.s_read !== 1'b0) begin
                errors++;
                $display("FAIL wr_strobe c%0d: wr=%b rd=%b want %b/0", c, bus.s_write, bus.s_read, c == 1);
            end
            checks++;
            if (bus.m_ack !== ((c == 3) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL wr_ack c%0d: got %b", c, bus.m_ack);
            end
            if (c == 1) begin
                checks++;
                if (bus.s_address !== 11'h020 || bus.s_data_in !== 32'hDEADBEEF || bus.s_be !== 4'b0001) begin
                    errors++;
                    $display("FAIL wr_bus: addr=%h data=%h be=%b want 020/deadbeef/0001",
                             bus.s_address, bus.s_data_in, bus.s_be);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.m_rdata !== 32'h0000A5A5) begin
                    errors++; $display("FAIL wr_rdata_kept: got %h want 0000a5a5", bus.m_rdata);
                end
                bus.m_req = 2'b00;
            end
        end
    endtask

    task automatic test_contention();
        int n = 0;
        int prev = 0;
        logic want;
        bus.m0_addr = 11'h100; bus.m1_addr = 11'h200; bus.m_we = 2'b00; bus.m_req = 2'b11;
        for (int k = 0; k < 40 && n < 5; k++) begin
            step();
            if (bus.m_ack != 2'b00) begin
                n++;
                want = (n == 5) ? 1'b1 : (RR ? logic'((n - 1) % 2) : 1'b0);
                checks++;
                if (bus.m_ack !== (want ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL tie_grant n%0d: ack=%b want master %0d", n, bus.m_ack, want);
                end
                if (n > 1) begin
                    checks++;
                    if (cyc - prev != AC + 2) begin
                        errors++; $display("FAIL tie_spacing n%0d: got %0d want %0d", n, cyc - prev, AC + 2);
                    end
                end
                prev = cyc;
                if (n == 4) bus.m_req[0] = 1'b0;
                if (n == 5) bus.m_req[1] = 1'b0;
            end
        end
        checks++;
        if (n != 5) begin
            errors++; $display("FAIL tie_timeout: acks=%0d want 5", n);
        end
        bus.m_req = 2'b00;
        step();
    endtask

    task automatic test_long_access();
        s4_data = 32'h1;
        bus4.m0_addr = 11'h0AB; bus4.m_we = 2'b00; bus4.m_req = 2'b01;
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++;
            if (bus4.s_read !== (c == 1)) begin
                errors++; $display("FAIL long_strobe c%0d: got %b want %b", c, bus4.s_read, c == 1);
            end
            checks++;
            if (bus4.m_ack !== ((c == 5) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL long_ack c%0d: got %b", c, bus4.m_ack);
            end
            if (c == 4) begin
                checks++;
                if (bus4.s_address !== 11'h0AB) begin
                    errors++; $display("FAIL long_addr_hold: got %h want 0ab", bus4.s_address);
                end
                s4_data = 32'h2;
            end
            if (c == 5) begin
                checks++;
                if (bus4.m_rdata !== 32'h2) begin
                    errors++; $display("FAIL long_capture: got %h want 00000002", bus4.m_rdata);
                end
                bus4.m_req = 2'b00;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int t0;
        bit found = 1'b0;
        slv_fixed_en = 1'b1; slv_fixed = 32'h12345678;
        bus.m0_addr = 11'h033; bus.m_we = 2'b00; bus.m_req = 2'b01;
        step();
        checks++;
        if (bus.s_read !== 1'b1) begin
            errors++; $display("FAIL rstmid_strobe: got %b want 1", bus.s_read);
        end
        step();
        rst = 1'b1; bus.m_req = 2'b00;
        step();
        rst = 1'b0;
        checks++;
        if (bus.m_ack !== 2'b00 || bus.m_rdata !== 32'd0 || bus.s_read !== 1'b0 ||
            bus.s_address !== 11'd0 || bus.s_be !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: ack=%b rdata=%h rd=%b addr=%h be=%h want 0",
                     bus.m_ack, bus.m_rdata, bus.s_read, bus.s_address, bus.s_be);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.m_ack !== 2'b00) begin
                errors++; $display("FAIL rstmid_no_ack k%0d: got %b want 00", k, bus.m_ack);
            end
        end
        bus.m0_addr = 11'h044; bus.m1_addr = 11'h055; bus.m_we = 2'b00; bus.m_req = 2'b11;
        t0 = cyc;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (bus.m_ack != 2'b00) begin
                found = 1'b1;
                checks++;
                if (bus.m_ack !== 2'b01 || cyc - t0 != AC + 1) begin
                    errors++;
                    $display("FAIL rstmid_fresh: ack=%b at +%0d want 01 at +%0d", bus.m_ack, cyc - t0, AC + 1);
                end
                checks++;
                if (bus.m_rdata !== 32'h12345678) begin
                    errors++; $display("FAIL rstmid_fresh_data: got %h want 12345678", bus.m_rdata);
                end
                bus.m_req = 2'b00;
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rstmid_timeout: no ack seen, want 01");
        end
        step();
    endtask

    task automatic test_drop_req();
        slv_fixed_en = 1'b1; slv_fixed = 32'hCAFEF00D;
        bus.m1_addr = 11'h066; bus.m_we = 2'b00; bus.m_req = 2'b10;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) bus.m_req = 2'b00;
            checks++;
            if (bus.m_ack !== ((c == 3) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL drop_ack c%0d: got %b", c, bus.m_ack);
            end
            if (c == 3) begin
                checks++;
                if (bus.m_rdata !== 32'hCAFEF00D) begin
                    errors++; $display("FAIL drop_data: got %h want cafef00d", bus.m_rdata);
                end
            end
        end
        // Request held through the ack: the following IDLE cycle starts a second write.
        bus.m0_addr = 11'h077; bus.m0_wdata = 32'h11223344; bus.m0_be = 4'hF;
        bus.m_we = 2'b01; bus.m_req = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if (bus.s_write !== (c == 1 || c == 5)) begin
                errors++; $display("FAIL hold_strobe c%0d: got %b want %b", c, bus.s_write, c == 1 || c == 5);
            end
            checks++;
            if (bus.m_ack !== ((c == 3 || c == 7) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL hold_ack c%0d: got %b", c, bus.m_ack);
            end
            if (c == 7) bus.m_req = 2'b00;
        end
    endtask

    task automatic test_random();
        int          c, free_at, ack_at, strobe_at, cap_at;
        logic        g, m_last, exp_we;
        logic [10:0] exp_addr;
        logic [31:0] exp_wdata, exp_rdata;
        logic [3:0]  exp_be;
        logic [1:0]  want_ack;
        idle_inputs();
        slv_fixed_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        free_at = cyc; ack_at = -1; strobe_at = -1; cap_at = -1;
        g = 1'b0; m_last = 1'b1; exp_we = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_be = '0;
        for (int it = 0; it < 600; it++) begin
            c = cyc;
            if (c == ack_at && !exp_we) exp_rdata = rd_fn(exp_addr, cap_at);
            want_ack = (c == ack_at) ? (g ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (bus.m_ack !== want_ack) begin
                errors++; $display("FAIL rnd_ack cyc%0d: got %b want %b", c, bus.m_ack, want_ack);
            end
            checks++;
            if (bus.s_read !== (c == strobe_at && !exp_we) || bus.s_write !== (c == strobe_at && exp_we)) begin
                errors++;
                $display("FAIL rnd_strobe cyc%0d: rd=%b wr=%b want %b/%b", c, bus.s_read, bus.s_write,
                         c == strobe_at && !exp_we, c == strobe_at && exp_we);
            end
            checks++;
            if (bus.s_address !== exp_addr || bus.s_data_in !== exp_wdata || bus.s_be !== exp_be) begin
                errors++;
                $display("FAIL rnd_bus cyc%0d: addr=%h data=%h be=%h want %h/%h/%h", c,
                         bus.s_address, bus.s_data_in, bus.s_be, exp_addr, exp_wdata, exp_be);
            end
            checks++;
            if (bus.m_rdata !== exp_rdata) begin
                errors++; $display("FAIL rnd_rdata cyc%0d: got %h want %h", c, bus.m_rdata, exp_rdata);
            end
            for (int i = 0; i < 2; i++) begin
                if (c == ack_at && g == i[0]) begin
                    if ($urandom_range(3) != 0) bus.m_req[i] = 1'b0;
                end else if (bus.m_req[i] && g == i[0] && c >= strobe_at && c < ack_at &&
                             $urandom_range(7) == 0) begin
                    bus.m_req[i] = 1'b0;
                end else if (!bus.m_req[i] && $urandom_range(2) == 0) begin
                    bus.m_we[i] = 1'($urandom);
                    if (i == 0) begin
                        bus.m0_addr = 11'($urandom); bus.m0_wdata = $urandom; bus.m0_be = 4'($urandom);
                    end else begin
                        bus.m1_addr = 11'($urandom); bus.m1_wdata = $urandom; bus.m1_be = 4'($urandom);
                    end
                    bus.m_req[i] = 1'b1;
                end
            end
            if ($urandom_range(79) == 0) begin
                rst = 1'b1; bus.m_req = 2'b00;
                free_at = c + 1; ack_at = -1; strobe_at = -1; cap_at = -1;
                m_last = 1'b1; exp_we = 1'b0;
                exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_be = '0;
            end else begin
                rst = 1'b0;
                if (c >= free_at && bus.m_req != 2'b00) begin
                    g = pick(bus.m_req, m_last);
                    m_last = g;
                    exp_we    = bus.m_we[g];
                    exp_addr  = g ? bus.m1_addr  : bus.m0_addr;
                    exp_wdata = g ? bus.m1_wdata : bus.m0_wdata;
                    exp_be    = g ? bus.m1_be    : bus.m0_be;
                    strobe_at = c + 1; cap_at = c + AC; ack_at = c + AC + 1; free_at = c + AC + 2;
                end
            end
            step();
        end
        rst = 1'b0;
        bus.m_req = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_long_access();
        test_reset_mid_access();
        test_drop_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
